// File: rtl/myproject_sdiv_31s_15s_16_seq.sv
// Sequential signed divider (restoring, one quotient bit per clock) recovering a
// 16-bit signed factor from a 31-bit product; C semantics, saturating quotient.
module myproject_sdiv_31s_15s_16_seq #(
    parameter int DIVIDEND_WIDTH = 31,
    parameter int DIVISOR_WIDTH  = 15,
    parameter int QUOTIENT_WIDTH = 16
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      ap_start,
    output logic                      ap_ready,
    output logic                      ap_idle,
    output logic                      ap_done,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic [QUOTIENT_WIDTH-1:0] dout,
    output logic [DIVISOR_WIDTH-1:0]  rem,
    output logic                      ovf,
    output logic                      dbz
);

    localparam int AW = DIVIDEND_WIDTH + 1;
    localparam int BW = DIVISOR_WIDTH + 1;
    localparam int PW = (AW > BW + QUOTIENT_WIDTH) ? AW : BW + QUOTIENT_WIDTH;
    localparam int CW = $clog2(QUOTIENT_WIDTH);

    localparam logic [QUOTIENT_WIDTH-1:0] QMAX = {1'b0, {(QUOTIENT_WIDTH-1){1'b1}}};
    localparam logic [QUOTIENT_WIDTH-1:0] QMIN = {1'b1, {(QUOTIENT_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ITER  = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, next_state;

    logic [PW-1:0]             a_mag;
    logic [BW-1:0]             b_mag;
    logic                      sign_a;
    logic                      sign_q;
    logic [PW-1:0]             pr;
    logic [QUOTIENT_WIDTH-1:0] q;
    logic [CW-1:0]             cnt;
    logic                      dbz_flag;
    logic                      ovf_flag;

    logic [PW-1:0]             a_ext;
    logic [PW-1:0]             a_abs;
    logic [BW-1:0]             b_ext_in;
    logic [BW-1:0]             b_abs;
    logic [PW-1:0]             b_ext;
    logic [PW-1:0]             b_lim;
    logic [PW-1:0]             trial;
    logic [CW-1:0]             bit_idx;
    logic                      is_dbz;
    logic                      is_pre_ovf;
    logic                      last_iter;

    logic [DIVISOR_WIDTH-1:0]  r_low;
    logic [QUOTIENT_WIDTH-1:0] fix_dout;
    logic [DIVISOR_WIDTH-1:0]  fix_rem;
    logic                      fix_ovf;

    // Operand magnitudes, widened so the most negative value is representable
    always_comb begin
        a_ext    = {{(PW-DIVIDEND_WIDTH){din0[DIVIDEND_WIDTH-1]}}, din0};
        a_abs    = din0[DIVIDEND_WIDTH-1] ? -a_ext : a_ext;
        b_ext_in = {din1[DIVISOR_WIDTH-1], din1};
        b_abs    = din1[DIVISOR_WIDTH-1] ? -b_ext_in : b_ext_in;
    end

    always_comb begin
        b_ext      = {{(PW-BW){1'b0}}, b_mag};
        b_lim      = b_ext << QUOTIENT_WIDTH;
        bit_idx    = CW'(QUOTIENT_WIDTH-1) - cnt;
        trial      = b_ext << bit_idx;
        is_dbz     = (b_mag == '0);
        is_pre_ovf = !is_dbz && (a_mag >= b_lim);
        last_iter  = (cnt == CW'(QUOTIENT_WIDTH-1));
    end

    // State register
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ap_start) next_state = CHECK;
            CHECK:   next_state = (is_dbz || is_pre_ovf) ? FIX : ITER;
            ITER:    if (last_iter) next_state = FIX;
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        ap_idle  = (state == IDLE);
        ap_ready = (state == IDLE) && ap_start;
        ap_done  = (state == DONE);
    end

    // Final sign application and saturation
    always_comb begin
        r_low    = pr[DIVISOR_WIDTH-1:0];
        fix_dout = '0;
        fix_rem  = '0;
        fix_ovf  = 1'b0;
        if (dbz_flag) begin
            fix_dout = sign_a ? QMIN : QMAX;
        end else if (ovf_flag) begin
            fix_dout = sign_q ? QMIN : QMAX;
            fix_ovf  = 1'b1;
        end else if (sign_q) begin
            if (q > QMIN) begin
                fix_dout = QMIN;
                fix_ovf  = 1'b1;
            end else begin
                fix_dout = -q;
                fix_rem  = sign_a ? -r_low : r_low;
            end
        end else begin
            if (q > QMAX) begin
                fix_dout = QMAX;
                fix_ovf  = 1'b1;
            end else begin
                fix_dout = q;
                fix_rem  = sign_a ? -r_low : r_low;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            a_mag    <= '0;
            b_mag    <= '0;
            sign_a   <= 1'b0;
            sign_q   <= 1'b0;
            pr       <= '0;
            q        <= '0;
            cnt      <= '0;
            dbz_flag <= 1'b0;
            ovf_flag <= 1'b0;
            dout     <= '0;
            rem      <= '0;
            ovf      <= 1'b0;
            dbz      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        a_mag  <= a_abs;
                        b_mag  <= b_abs;
                        sign_a <= din0[DIVIDEND_WIDTH-1];
                        sign_q <= din0[DIVIDEND_WIDTH-1] ^ din1[DIVISOR_WIDTH-1];
                    end
                end
                CHECK: begin
                    dbz_flag <= is_dbz;
                    ovf_flag <= is_pre_ovf;
                    pr       <= a_mag;
                    q        <= '0;
                    cnt      <= '0;
                end
                ITER: begin
                    if (pr >= trial) begin
                        pr         <= pr - trial;
                        q[bit_idx] <= 1'b1;
                    end
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    dout <= fix_dout;
                    rem  <= fix_rem;
                    ovf  <= fix_ovf;
                    dbz  <= dbz_flag;
                end
                default: ;
            endcase
        end
    end

endmodule
